mem_stage: RTL
==============

Name: mem_stage

Overview:
- Fourth pipeline stage of the lapido core. Consumes the EX/MEM register outputs of the execute stage.
- Performs data-memory access on an internal word-addressed RAM.
- Resolves pc-relative branches (beq/bne) and flag jumps (jt/jf) and drives branch_taken/branch_addr back to fetch/decode/execute.
- Holds the MEM/WB pipeline register and supplies the forwarding data for EX.

Parameters:
- DATA_WIDTH, 32, width of GPRs, ALU result, memory words.
- PC_WIDTH, 32, width of program-counter values.
- MEM_DEPTH, 256, data-memory words; address index width = $clog2(MEM_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active low.
- mem_write_enable  in  1  store request.
- sel_beq_bne  in  1  0=beq, 1=bne.
- sel_jt_jf  in  1  0=jt (jump if flag set), 1=jf (jump if flag clear).
- is_branch  in  1  instruction is a control transfer.
- sel_jflag_branch  in  1  0=beq/bne, 1=jt/jf.
- wb_res_mux  in  2  writeback source select.
- reg_write_enable  in  1  GPR write request.
- imm  in  DATA_WIDTH  immediate; imm[2:0] = flag select for jt/jf.
- next_pc  in  PC_WIDTH  pc+1 of the instruction.
- branch_addr_in  in  PC_WIDTH  computed branch target.
- alu_res  in  DATA_WIDTH  ALU result.
- mem_addr  in  DATA_WIDTH  word address.
- mem_data  in  DATA_WIDTH  store data.
- flags  in  6  bit0 zero, bit1 negative, bit2 carry, bit3 overflow, bit4 positive, bit5 constant-true.
- reg_dest  in  5  destination GPR.
- branch_taken  out  1  control transfer resolved taken (combinational).
- branch_addr  out  PC_WIDTH  target (combinational, = branch_addr_in).
- EX_MEM_data  out  DATA_WIDTH  forward source = alu_res (combinational).
- out_wb_res_mux  out  2  registered.
- out_reg_write_enable  out  1  registered.
- out_reg_dest  out  5  registered.
- MEM_WB_data  out  DATA_WIDTH  selected writeback data (combinational from MEM/WB register and RAM read port).

Behaviour:
- **Reset.** rst low asynchronously clears all MEM/WB register fields and the RAM read register to 0. Writes are suppressed while rst is low. RAM contents are not cleared.
- **Branch resolution** (combinational, valid in the same cycle the instruction is in MEM):
  - Taken only if is_branch=1.
  - sel_jflag_branch=0: taken = flags[0] XOR sel_beq_bne (beq on zero, bne on not-zero).
  - sel_jflag_branch=1: f = flags[imm[2:0]] for imm[2:0] 0..5, f = 0 for 6..7; taken = f XOR sel_jt_jf.
- **Stores.**
  - Synchronous write on the rising edge when mem_write_enable=1 and rst high.
  - Index = mem_addr[idx-1:0].
  - If mem_addr >= MEM_DEPTH, the write is dropped.
- **Loads.**
  - Synchronous read every cycle of mem_addr; data is available one cycle later, aligned with the MEM/WB register.
  - Out-of-range address reads 0.
  - Default is read-before-write: a same-cycle write to the same index returns the old word.
- **MEM/WB register.**
  - Latches wb_res_mux, reg_write_enable, reg_dest, alu_res, imm, next_pc every edge. No stall or enable input.
  - Latency is one cycle.
- **Writeback select** (MEM_WB_data): 00 = registered alu_res, 01 = RAM read data, 10 = registered imm, 11 = registered next_pc zero-extended/truncated to DATA_WIDTH.
- **Taken branch.** The instruction in MEM still completes normally (branches carry reg_write_enable=0 from decode). Flushing of younger stages is done by the upstream stages.
- **No internal state machine.** The stage is a strict one-cycle pipeline; back-to-back loads/stores at full rate are required.

Optional Feature:
- Macro MEM_WRITE_FIRST_EN.
- Defined: the RAM read port is write-first. A store and a read of the same index in the same cycle return the new store data next cycle.
- Undefined: read-before-write as above.

Test Plan:
- Reset mid-stream: drive reg_write_enable=1, alu_res=0x55 → after edge out_reg_write_enable=1. Assert rst=0 between edges → out_reg_write_enable, out_reg_dest, MEM_WB_data go to 0 immediately. RAM word stored before reset is still readable after.
- Store/load: store 0xDEADBEEF at addr 5, next cycle load addr 5 with wb_res_mux=01, reg_dest=7 → cycle after: MEM_WB_data=0xDEADBEEF, out_reg_dest=7.
- Same-cycle write/read at addr 9 (old 0x11, new 0x22) → MEM_WB_data=0x11 without the macro, 0x22 with MEM_WRITE_FIRST_EN.
- Branches:
  - is_branch=1, sel_jflag_branch=0, sel_beq_bne=0, flags=6'b000001, branch_addr_in=0x40 → branch_taken=1, branch_addr=0x40.
  - Same with sel_beq_bne=1 → branch_taken=0.
  - is_branch=0 → branch_taken=0.
- Flag jumps:
  - jt with imm[2:0]=2, flags[2]=1 → taken.
  - jf same → not taken.
  - imm[2:0]=7, jf → taken.
  - imm[2:0]=5 (constant-true), jt → taken.
- Out-of-range and writeback mux:
  - Store to addr 300 (MEM_DEPTH=256) → no RAM word changes. Load from addr 300 → MEM_WB_data=0.
  - wb_res_mux=10 with imm=0x1234 → MEM_WB_data=0x1234.
  - wb_res_mux=11 with next_pc=0x81 → MEM_WB_data=0x81.

Source files
------------

// File: rtl/mem_stage.sv
// lapido MEM stage: branch resolution, word-addressed data RAM and the MEM/WB register.
// Optional macro MEM_WRITE_FIRST_EN makes the RAM read port write-first (default read-before-write).
module mem_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_write_enable,
    input  logic                  sel_beq_bne,
    input  logic                  sel_jt_jf,
    input  logic                  is_branch,
    input  logic                  sel_jflag_branch,
    input  logic [1:0]            wb_res_mux,
    input  logic                  reg_write_enable,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [PC_WIDTH-1:0]   next_pc,
    input  logic [PC_WIDTH-1:0]   branch_addr_in,
    input  logic [DATA_WIDTH-1:0] alu_res,
    input  logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [5:0]            flags,
    input  logic [4:0]            reg_dest,
    output logic                  branch_taken,
    output logic [PC_WIDTH-1:0]   branch_addr,
    output logic [DATA_WIDTH-1:0] EX_MEM_data,
    output logic [1:0]            out_wb_res_mux,
    output logic                  out_reg_write_enable,
    output logic [4:0]            out_reg_dest,
    output logic [DATA_WIDTH-1:0] MEM_WB_data
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;
    localparam logic [1:0] WB_PC  = 2'b11;

    // Flag select for jt/jf; codes 6 and 7 select a constant zero.
    logic flag_sel_c;
    always_comb begin
        flag_sel_c = 1'b0;
        case (imm[2:0])
            3'd0:    flag_sel_c = flags[0];
            3'd1:    flag_sel_c = flags[1];
            3'd2:    flag_sel_c = flags[2];
            3'd3:    flag_sel_c = flags[3];
            3'd4:    flag_sel_c = flags[4];
            3'd5:    flag_sel_c = flags[5];
            default: flag_sel_c = 1'b0;
        endcase
    end

    logic cond_c;
    always_comb begin
        cond_c = 1'b0;
        if (sel_jflag_branch) begin
            cond_c = flag_sel_c ^ sel_jt_jf;
        end else begin
            cond_c = flags[0] ^ sel_beq_bne;
        end
    end

    assign branch_taken = is_branch & cond_c;
    assign branch_addr  = branch_addr_in;
    assign EX_MEM_data  = alu_res;

    // Data RAM: addresses at or beyond MEM_DEPTH neither write nor read.
    logic                  addr_ok_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  wr_en_c;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    assign addr_ok_c = (mem_addr < DATA_WIDTH'(MEM_DEPTH));
    assign idx_c     = mem_addr[IDX_W-1:0];
    assign wr_en_c   = rst & mem_write_enable & addr_ok_c;

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[idx_c] <= mem_data;
        end
    end

    logic [DATA_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0] rd_q;

    always_comb begin
        rd_d = '0;
        if (addr_ok_c) begin
`ifdef MEM_WRITE_FIRST_EN
            if (wr_en_c) begin
                rd_d = mem_data;
            end else begin
                rd_d = mem_q[idx_c];
            end
`else
            rd_d = mem_q[idx_c];
`endif
        end
    end

    // MEM/WB pipeline register, free-running with no stall.
    logic [1:0]            wb_mux_q;
    logic                  rwe_q;
    logic [4:0]            dest_q;
    logic [DATA_WIDTH-1:0] alu_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [PC_WIDTH-1:0]   pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q     <= '0;
            wb_mux_q <= '0;
            rwe_q    <= 1'b0;
            dest_q   <= '0;
            alu_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
        end else begin
            rd_q     <= rd_d;
            wb_mux_q <= wb_res_mux;
            rwe_q    <= reg_write_enable;
            dest_q   <= reg_dest;
            alu_q    <= alu_res;
            imm_q    <= imm;
            pc_q     <= next_pc;
        end
    end

    assign out_wb_res_mux       = wb_mux_q;
    assign out_reg_write_enable = rwe_q;
    assign out_reg_dest         = dest_q;

    always_comb begin
        MEM_WB_data = alu_q;
        case (wb_mux_q)
            WB_ALU:  MEM_WB_data = alu_q;
            WB_MEM:  MEM_WB_data = rd_q;
            WB_IMM:  MEM_WB_data = imm_q;
            WB_PC:   MEM_WB_data = DATA_WIDTH'(pc_q);
            default: MEM_WB_data = alu_q;
        endcase
    end

endmodule
